// File: rtl/ucq_multi.sv
// Multi-port unit clause queue: collects up to N_PUSH signed literals per cycle,
// drops duplicates, flags complementary pairs, and presents them FWFT one at a time.
module ucq_multi #(
  parameter int LIT_W  = 10,
  parameter int DEPTH  = 8,
  parameter int N_PUSH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [N_PUSH-1:0]              push_valid,
  input  logic signed [N_PUSH*LIT_W-1:0] push_lit,
  output logic                           push_ready,
  input  logic                           pop,
  output logic                           out_valid,
  output logic signed [LIT_W-1:0]        out_lit,
  output logic [$clog2(DEPTH):0]         count,
  output logic                           full,
  output logic                           empty,
  output logic                           conflict
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic signed [LIT_W-1:0] mem [DEPTH];
  logic [PW-1:0]           head, tail;
  logic [DEPTH-1:0]        occ;

  logic signed [LIT_W-1:0] lane_lit [N_PUSH];
  logic signed [LIT_W-1:0] neg_lit  [N_PUSH];
  logic [N_PUSH-1:0]       accept;
  logic [N_PUSH-1:0]       dup, cmp;
  logic [PW-1:0]           slot [N_PUSH];
  logic [PW-1:0]           n_acc;
  logic                    conf_hit;

  assign count      = tail - head;
  assign empty      = (count == '0);
  assign full       = (count == PW'(DEPTH));
  assign push_ready = (count <= PW'(DEPTH - N_PUSH));
  assign out_valid  = !empty;
  assign out_lit    = empty ? '0 : mem[head[AW-1:0]];

  // An entry is occupied when its distance from head is below the current count.
  for (genvar e = 0; e < DEPTH; e++) begin : g_occ
    logic [AW-1:0] off;
    assign off    = AW'(e) - head[AW-1:0];
    assign occ[e] = ({1'b0, off} < count);
  end

  for (genvar l = 0; l < N_PUSH; l++) begin : g_lane
    assign lane_lit[l] = push_lit[l*LIT_W +: LIT_W];
    assign neg_lit[l]  = -lane_lit[l];
  end

  // Lanes are filtered in ascending order against stored entries and accepted lower lanes.
  always_comb begin
    accept   = '0;
    dup      = '0;
    cmp      = '0;
    conf_hit = 1'b0;
    n_acc    = '0;
    for (int l = 0; l < N_PUSH; l++) slot[l] = '0;
    for (int l = 0; l < N_PUSH; l++) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (occ[e] && mem[e] == lane_lit[l]) dup[l] = 1'b1;
        if (occ[e] && mem[e] == neg_lit[l])  cmp[l] = 1'b1;
      end
      for (int k = 0; k < N_PUSH; k++) begin
        if (k < l && accept[k] && lane_lit[k] == lane_lit[l]) dup[l] = 1'b1;
        if (k < l && accept[k] && lane_lit[k] == neg_lit[l])  cmp[l] = 1'b1;
      end
      if (push_ready && push_valid[l] && lane_lit[l] != '0 && !dup[l]) begin
        if (cmp[l]) begin
          conf_hit = 1'b1;
        end else begin
          accept[l] = 1'b1;
          slot[l]   = n_acc;
          n_acc     = n_acc + PW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      conflict <= 1'b0;
    end else if (flush) begin
      head     <= '0;
      tail     <= '0;
      conflict <= 1'b0;
    end else begin
      tail <= tail + n_acc;
      if (pop && out_valid) head <= head + PW'(1);
      if (conf_hit) conflict <= 1'b1;
    end
  end

  // Truncating tail+slot to the entry index gives the modulo-DEPTH wrap for free.
  always_ff @(posedge clk) begin
    if (!flush) begin
      for (int l = 0; l < N_PUSH; l++) begin
        if (accept[l]) mem[AW'(tail + slot[l])] <= lane_lit[l];
      end
    end
  end

endmodule

// File: tb/tb_ucq_multi.sv
// Randomized and directed bench for ucq_multi against a queue-based reference model.
module tb_ucq_multi;

  localparam int LIT_W  = 10;
  localparam int DEPTH  = 8;
  localparam int N_PUSH = 2;

  logic                           clk = 0;
  logic                           rst = 1;
  logic                           flush = 0;
  logic [N_PUSH-1:0]              push_valid = '0;
  logic signed [N_PUSH*LIT_W-1:0] push_lit = '0;
  logic                           push_ready;
  logic                           pop = 0;
  logic                           out_valid;
  logic signed [LIT_W-1:0]        out_lit;
  logic [$clog2(DEPTH):0]         count;
  logic                           full, empty, conflict;

  int total = 0;
  int bad   = 0;
  int mq[$];
  bit mconf = 0;

  ucq_multi #(.LIT_W(LIT_W), .DEPTH(DEPTH), .N_PUSH(N_PUSH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .push_valid(push_valid), .push_lit(push_lit),
    .push_ready(push_ready), .pop(pop), .out_valid(out_valid), .out_lit(out_lit),
    .count(count), .full(full), .empty(empty), .conflict(conflict)
  );

  always #5 clk = ~clk;

  // Reference behaviour: set semantics over the queued literals plus accepted lower lanes.
  task automatic model_step(input logic [1:0] pv, input int a, input int b, input bit p, input bit f);
    int acc[$];
    int lits[2];
    bit dp, cp;
    lits[0] = a;
    lits[1] = b;
    if (f) begin
      mq.delete();
      mconf = 0;
      return;
    end
    if (mq.size() <= DEPTH - N_PUSH) begin
      for (int l = 0; l < 2; l++) begin
        if (pv[l] && lits[l] != 0) begin
          dp = 0;
          cp = 0;
          foreach (mq[i]) begin
            if (mq[i] == lits[l]) dp = 1;
            if (mq[i] == -lits[l]) cp = 1;
          end
          foreach (acc[i]) begin
            if (acc[i] == lits[l]) dp = 1;
            if (acc[i] == -lits[l]) cp = 1;
          end
          if (!dp) begin
            if (cp) mconf = 1;
            else acc.push_back(lits[l]);
          end
        end
      end
    end
    if (p && mq.size() > 0) void'(mq.pop_front());
    foreach (acc[i]) mq.push_back(acc[i]);
  endtask

  task automatic cycle(input logic [1:0] pv, input int a, input int b, input bit p, input bit f);
    logic signed [LIT_W-1:0] la, lb;
    la = LIT_W'(a);
    lb = LIT_W'(b);
    push_valid = pv;
    push_lit   = {lb, la};
    pop        = p;
    flush      = f;
    model_step(pv, a, b, p, f);
    @(posedge clk);
    #1;
    push_valid = '0;
    pop        = 0;
    flush      = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (3) cycle(2'b00, 0, 0, 0, 0);
    total++; if (empty !== 1'b1) begin bad++; $display("[TB] FAIL reset_empty: got %0b expected 1", empty); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", out_valid); end
    total++; if (out_lit !== '0) begin bad++; $display("[TB] FAIL reset_out_lit: got %0d expected 0", out_lit); end
    total++; if (count !== '0) begin bad++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
    total++; if (push_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_push_ready: got %0b expected 1", push_ready); end
    total++; if (conflict !== 1'b0) begin bad++; $display("[TB] FAIL reset_conflict: got %0b expected 0", conflict); end
  endtask

  task automatic test_order;
    int exp[4] = '{5, -3, 7, 2};
    cycle(2'b11, 5, -3, 0, 0);
    total++; if (count !== 2) begin bad++; $display("[TB] FAIL order_count1: got %0d expected 2", count); end
    cycle(2'b11, 7, 2, 0, 0);
    total++; if (count !== 4) begin bad++; $display("[TB] FAIL order_count2: got %0d expected 4", count); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (int'(out_lit) !== exp[i]) begin bad++; $display("[TB] FAIL order_pop%0d: got %0d expected %0d", i, out_lit, exp[i]); end
      cycle(2'b00, 0, 0, 1, 0);
    end
    total++; if (empty !== 1'b1) begin bad++; $display("[TB] FAIL order_empty: got %0b expected 1", empty); end
  endtask

  task automatic test_duplicate;
    cycle(2'b00, 0, 0, 0, 1);
    cycle(2'b01, 4, 0, 0, 0);
    cycle(2'b11, 4, 9, 0, 0);
    cycle(2'b11, 9, 9, 0, 0);
    total++; if (count !== 2) begin bad++; $display("[TB] FAIL dup_count: got %0d expected 2", count); end
    total++; if (conflict !== 1'b0) begin bad++; $display("[TB] FAIL dup_conflict: got %0b expected 0", conflict); end
    total++; if (out_lit !== 10'sd4) begin bad++; $display("[TB] FAIL dup_head: got %0d expected 4", out_lit); end
    cycle(2'b00, 0, 0, 1, 0);
    total++; if (out_lit !== 10'sd9) begin bad++; $display("[TB] FAIL dup_second: got %0d expected 9", out_lit); end
  endtask

  task automatic test_conflict;
    cycle(2'b00, 0, 0, 0, 1);
    cycle(2'b01, 6, 0, 0, 0);
    cycle(2'b11, -6, 1, 0, 0);
    total++; if (conflict !== 1'b1) begin bad++; $display("[TB] FAIL conf_set: got %0b expected 1", conflict); end
    total++; if (count !== 2) begin bad++; $display("[TB] FAIL conf_count: got %0d expected 2", count); end
    cycle(2'b00, 0, 0, 1, 0);
    total++; if (out_lit !== 10'sd1) begin bad++; $display("[TB] FAIL conf_second: got %0d expected 1", out_lit); end
    cycle(2'b00, 0, 0, 1, 0);
    total++; if (conflict !== 1'b1) begin bad++; $display("[TB] FAIL conf_sticky: got %0b expected 1", conflict); end
    cycle(2'b00, 0, 0, 0, 1);
    total++; if (conflict !== 1'b0 || count !== 0) begin bad++; $display("[TB] FAIL conf_flush: got conflict=%0b count=%0d expected 0/0", conflict, count); end
  endtask

  task automatic test_wrap;
    int exp[8] = '{11, 12, 13, 14, 15, 16, 1, 2};
    cycle(2'b00, 0, 0, 0, 1);
    cycle(2'b11, 10, 11, 0, 0);
    cycle(2'b11, 12, 13, 0, 0);
    cycle(2'b11, 14, 15, 0, 0);
    cycle(2'b01, 16, 0, 0, 0);
    total++; if (push_ready !== 1'b0) begin bad++; $display("[TB] FAIL wrap_ready: got %0b expected 0", push_ready); end
    cycle(2'b11, 1, 2, 1, 0);
    total++; if (count !== 6) begin bad++; $display("[TB] FAIL wrap_blocked: got %0d expected 6", count); end
    cycle(2'b11, 1, 2, 0, 0);
    total++; if (count !== 8 || full !== 1'b1) begin bad++; $display("[TB] FAIL wrap_full: got count=%0d full=%0b expected 8/1", count, full); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (int'(out_lit) !== exp[i]) begin bad++; $display("[TB] FAIL wrap_pop%0d: got %0d expected %0d", i, out_lit, exp[i]); end
      cycle(2'b00, 0, 0, 1, 0);
    end
    total++; if (empty !== 1'b1) begin bad++; $display("[TB] FAIL wrap_empty: got %0b expected 1", empty); end
  endtask

  task automatic test_async_reset;
    cycle(2'b00, 0, 0, 0, 1);
    cycle(2'b11, 1, 2, 0, 0);
    cycle(2'b11, 3, -3, 0, 0);
    cycle(2'b11, 4, 5, 0, 0);
    total++; if (count !== 5 || conflict !== 1'b1) begin bad++; $display("[TB] FAIL arst_pre: got count=%0d conflict=%0b expected 5/1", count, conflict); end
    #3 rst = 1;
    #1;
    total++; if (count !== 0 || empty !== 1'b1 || full !== 1'b0) begin bad++; $display("[TB] FAIL arst_count: got count=%0d empty=%0b full=%0b expected 0/1/0", count, empty, full); end
    total++; if (out_valid !== 1'b0 || out_lit !== '0) begin bad++; $display("[TB] FAIL arst_out: got valid=%0b lit=%0d expected 0/0", out_valid, out_lit); end
    total++; if (push_ready !== 1'b1 || conflict !== 1'b0) begin bad++; $display("[TB] FAIL arst_flags: got ready=%0b conflict=%0b expected 1/0", push_ready, conflict); end
    mq.delete();
    mconf = 0;
    @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic test_random;
    int a, b, exp_lit;
    logic [1:0] pv;
    bit p, f;
    cycle(2'b00, 0, 0, 0, 1);
    for (int n = 0; n < 400; n++) begin
      pv = 2'($urandom_range(0, 3));
      a  = int'($urandom_range(0, 12)) - 6;
      b  = int'($urandom_range(0, 12)) - 6;
      p  = ($urandom_range(0, 2) == 0);
      f  = ($urandom_range(0, 40) == 0);
      cycle(pv, a, b, p, f);
      exp_lit = (mq.size() > 0) ? mq[0] : 0;
      total++; if (int'(count) !== mq.size()) begin bad++; $display("[TB] FAIL rnd_count@%0d: got %0d expected %0d", n, count, mq.size()); end
      total++; if (int'(out_lit) !== exp_lit) begin bad++; $display("[TB] FAIL rnd_head@%0d: got %0d expected %0d", n, out_lit, exp_lit); end
      total++; if (conflict !== mconf) begin bad++; $display("[TB] FAIL rnd_conflict@%0d: got %0b expected %0b", n, conflict, mconf); end
      total++; if (push_ready !== (mq.size() <= DEPTH - N_PUSH)) begin bad++; $display("[TB] FAIL rnd_ready@%0d: got %0b expected %0b", n, push_ready, mq.size() <= DEPTH - N_PUSH); end
      total++; if (out_valid !== (mq.size() > 0)) begin bad++; $display("[TB] FAIL rnd_valid@%0d: got %0b expected %0b", n, out_valid, mq.size() > 0); end
    end
  endtask

  initial begin
    test_reset();
    test_order();
    test_duplicate();
    test_conflict();
    test_wrap();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ucq_multi.md
# ucq_multi

Multi-port unit clause queue that collects unit literals from `N_PUSH` process engines in a single cycle and presents them, one at a time, to the unit clause arbiter. The literals are signed and nonzero; a negative value is a negated variable. The block stores only one copy of each literal. When a literal's complement is already queued, or arrives in the same cycle, it raises a sticky conflict flag. It generalises the single-port unit clause FIFO in three ways: configurable literal width, configurable depth, and configurable push-lane count. It also adds a first-word-fall-through output, an occupancy count and a synchronous flush.

## Interface
- `LIT_W`, default 10: signed literal width in bits, two's complement.
- `DEPTH`, default 8: number of storage entries; must be a power of 2 and at least `N_PUSH`.
- `N_PUSH`, default 2: number of push lanes, from 1 to 8.
- `clk`, in, 1: the single clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `flush`, in, 1: synchronous clear of the queue contents and of `conflict`.
- `push_valid`, in, `N_PUSH`: per-lane literal-valid strobe.
- `push_lit`, in, `N_PUSH`×`LIT_W` (signed): per-lane literal.
- `push_ready`, out, 1: high when at least `N_PUSH` entries are free.
- `pop`, in, 1: consumes the head entry.
- `out_valid`, out, 1: head entry is valid (queue not empty).
- `out_lit`, out, `LIT_W` (signed): head literal; driven 0 when the queue is empty.
- `count`, out, `$clog2(DEPTH)+1`: number of occupied entries.
- `full`, out, 1: `count == DEPTH`.
- `empty`, out, 1: `count == 0`.
- `conflict`, out, 1: sticky flag; a complementary literal pair was seen.

## Operation
- Storage is a circular buffer of `DEPTH` entries.
  - `head` and `tail` pointers are `$clog2(DEPTH)+1` bits wide, with an extra wrap bit.
  - `count` is computed as `tail - head`.
  - The pointers wrap naturally, modulo 2·`DEPTH`.
- Push admission is all-or-nothing.
  - If `push_ready` is 0, every lane is ignored that cycle and nothing is written.
  - `push_ready` is computed from the registered `count`. A pop in the same cycle does not add admission space.
- Per-lane filtering applies when the push is admitted. Lanes are evaluated in ascending lane index, lane 0 first.
  - A literal of 0 is ignored.
  - Duplicate: the literal equals an occupied entry or an accepted lower lane. The lane is dropped silently.
  - Complement: `-lit` equals an occupied entry or an accepted lower lane. `conflict` is set and the lane is dropped.
  - Otherwise the lane is accepted.
  - "Occupied entries" means all entries valid at the start of the cycle, including a head entry being popped that cycle.
  - `push_lit` must never be the most negative value; the block performs no check on it.
- Accepted lanes are compacted in lane order and written at `tail`, `tail+1`, and so on.
  - `tail` advances by the number of accepted lanes, 0 to `N_PUSH`.
- Pop:
  - When `pop` and `out_valid` are both high, `head` advances by 1.
  - When `pop` is high and `out_valid` is low, there is no effect.
- Simultaneous push and pop in one cycle are both applied. The next `count` equals `count` plus the number accepted, minus 1 for the pop.
- `flush` has priority over push and pop.
  - It clears `head`, `tail` and `conflict`.
  - Entry contents do not need clearing.
- `conflict` remains 1 until `flush` or `rst`. Push and pop continue to operate normally while it is set.

## Timing
- Reset (asynchronous assert):
  - `head = tail = 0`, `conflict = 0`.
  - Outputs: `count = 0`, `empty = 1`, `full = 0`, `out_valid = 0`, `out_lit = 0`, `push_ready = 1`.
- Output derivation:
  - `out_valid`, `out_lit`, `count`, `full`, `empty` and `push_ready` are combinational from registered state only. There is no input-to-output combinational path.
  - `conflict` is a register output.
- Latency:
  - A literal accepted at edge *k* is visible at `out_lit` after edge *k* when the queue was empty.
  - Pop-to-next-head is 1 cycle.
- Back-to-back:
  - Full-rate pop is sustained.
  - Push at `N_PUSH` literals per cycle is sustained while `count <= DEPTH - N_PUSH`.
- Wrap-around: a compacted multi-lane write that crosses the end of the buffer wraps the entry index modulo `DEPTH`.
- Flush with push in the same cycle: the push is discarded.

## Test plan
- Reset, then 3 cycles idle:
  - `empty = 1`, `out_valid = 0`, `out_lit = 0`, `count = 0`, `push_ready = 1`, `conflict = 0`.
- `N_PUSH = 2`, `DEPTH = 8`; push lanes {5, -3}, then {7, 2}:
  - `count` = 2, then 4.
  - Pops return 5, -3, 7, 2 in order; `empty = 1` afterwards.
- Queue holds {4}; push {4, 9}, then {9, 9}:
  - Only 9 is written; `count = 2`, `conflict = 0`.
- Queue holds {6}; push {-6, 1}:
  - `conflict = 1` next cycle; `count = 2` (6, 1).
  - `conflict` stays 1 through pops; `flush` clears it, with `count = 0`.
- Fill to `count = 7`; push {1, 2} with pop:
  - `push_ready = 0`, so nothing is written; `count = 6` afterwards.
  - Then push {1, 2}: `count = 8` and `full = 1`. The write crosses the pointer wrap, and the data pops out in order.
- Assert `rst` asynchronously, mid-cycle, while `count = 5`:
  - Outputs return to their reset values immediately, without waiting for a clock edge.
